pooling_max_unit: RTL and testbench

//  Max-pooling reduction stage that sits directly downstream of the pooling input interface.

---
 rtl/pooling_pkg.sv | 15 +
 rtl/pooling_fp_max.sv | 10 +
 rtl/pooling_max_unit.sv | 55 +++++
 tb/tb_pooling_max_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// pooling_pkg: shared float32 types, pooling geometry and raw-bit float max
package pooling_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int KERNEL_SIZE = 2;
   localparam int WIN = KERNEL_SIZE * KERNEL_SIZE;
   localparam int CNT_W = 8;
   typedef logic [DATA_WIDTH-1:0] fp32_t;
   function automatic fp32_t fp_max(fp32_t a, fp32_t b);
      logic both_zero;
      both_zero = (a[30:0] == '0) && (b[30:0] == '0);
      return (a[31] != b[31]) ? ((both_zero || !a[31]) ? a : b)
           : a[31]            ? ((b[30:0] < a[30:0]) ? b : a)
           :                    ((b[30:0] > a[30:0]) ? b : a);
   endfunction
endpackage

// File: rtl/pooling_fp_max.sv
// pooling_fp_max: combinational float32 max, ties keep a
module pooling_fp_max
   import pooling_pkg::*;
(
   input  fp32_t a,
   input  fp32_t b,
   output fp32_t y
);
   assign y = fp_max(a, b);
endmodule

// File: rtl/pooling_max_unit.sv
// pooling_max_unit: per-window float32 max reduction; POOLING_MAX_RELU_EN clamps negative results to zero
module pooling_max_unit
   import pooling_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      win_cnt
);
   localparam int EW = (WIN > 1) ? $clog2(WIN) : 1;
   logic [EW-1:0] elem_cnt;
   fp32_t max_reg, max_res, emit;
   logic first, last;
   assign first = (elem_cnt == '0);
   assign last = (elem_cnt == EW'(WIN - 1));
   pooling_fp_max u_max (.a(max_reg), .b(in_data), .y(max_res));
`ifdef POOLING_MAX_RELU_EN
   assign emit = max_res[DATA_WIDTH-1] ? '0 : max_res;
`else
   assign emit = max_res;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         elem_cnt <= '0;
         max_reg <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         busy <= 1'b0;
         win_cnt <= '0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            elem_cnt <= '0;
            busy <= 1'b0;
         end else if (in_valid) begin
            max_reg <= first ? in_data : max_res;
            if (last) begin
               elem_cnt <= '0;
               busy <= 1'b0;
               out_valid <= 1'b1;
               out_data <= emit;
               win_cnt <= win_cnt + 1'b1;
            end else begin
               elem_cnt <= elem_cnt + 1'b1;
               busy <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pooling_max_unit.sv
// tb_pooling_max_unit: directed checks of window max, gaps, flush, reset and counter wrap
module tb_pooling_max_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [31:0] out_data;
   logic        busy;
   logic [7:0]  win_cnt;
   int checks = 0;
   int failures = 0;
   int pulses = 0;
   logic [31:0] exp_neg, exp_mz, exp_b2;

   pooling_max_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_data(out_data), .busy(busy), .win_cnt(win_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic f);
      in_valid = v;
      in_data = d;
      flush = f;
      @(posedge clk);
      #1;
      pulses += int'(out_valid);
   endtask

   task automatic win4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b1, c, 1'b0);
      step(1'b1, d, 1'b0);
   endtask

   initial begin
`ifdef POOLING_MAX_RELU_EN
      exp_neg = 32'h0000_0000;
      exp_mz = 32'h0000_0000;
      exp_b2 = 32'h0000_0000;
`else
      exp_neg = 32'hBF00_0000;
      exp_mz = 32'h8000_0000;
      exp_b2 = 32'hBF80_0000;
`endif
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 32'h3F80_0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wcnt", 32'(win_cnt), 32'd0);
      rst = 1'b0;
      step(1'b1, 32'h3F80_0000, 1'b0);
      chk("pos_busy1", 32'(busy), 32'd1);
      chk("pos_nopulse1", 32'(out_valid), 32'd0);
      step(1'b1, 32'h4000_0000, 1'b0);
      step(1'b1, 32'h3F00_0000, 1'b0);
      chk("pos_nopulse3", 32'(out_valid), 32'd0);
      step(1'b1, 32'h3F80_0000, 1'b0);
      chk("pos_valid", 32'(out_valid), 32'd1);
      chk("pos_data", out_data, 32'h4000_0000);
      chk("pos_wcnt", 32'(win_cnt), 32'd1);
      chk("pos_busy_end", 32'(busy), 32'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("pos_pulse_len", 32'(out_valid), 32'd0);
      chk("pos_hold", out_data, 32'h4000_0000);
      win4(32'hBF80_0000, 32'hC040_0000, 32'hC040_0000, 32'hBF00_0000);
      chk("neg_valid", 32'(out_valid), 32'd1);
      chk("neg_data", out_data, exp_neg);
      chk("neg_wcnt", 32'(win_cnt), 32'd2);
      win4(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
      chk("mz_data", out_data, exp_mz);
      chk("mz_wcnt", 32'(win_cnt), 32'd3);
      pulses = 0;
      step(1'b1, 32'h3F80_0000, 1'b0);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h4040_0000, 1'b0);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      chk("gap_busy", 32'(busy), 32'd1);
      step(1'b1, 32'h4000_0000, 1'b0);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h3F80_0000, 1'b0);
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_data", out_data, 32'h4040_0000);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      chk("gap_pulses", 32'(pulses), 32'd1);
      chk("gap_wcnt", 32'(win_cnt), 32'd4);
      pulses = 0;
      win4(32'h3F80_0000, 32'h4080_0000, 32'h4000_0000, 32'h4040_0000);
      chk("b2b_valid_a", 32'(out_valid), 32'd1);
      chk("b2b_data_a", out_data, 32'h4080_0000);
      step(1'b1, 32'hC000_0000, 1'b0);
      chk("b2b_gap", 32'(out_valid), 32'd0);
      step(1'b1, 32'hBF80_0000, 1'b0);
      step(1'b1, 32'hC040_0000, 1'b0);
      step(1'b1, 32'hC080_0000, 1'b0);
      chk("b2b_valid_b", 32'(out_valid), 32'd1);
      chk("b2b_data_b", out_data, exp_b2);
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk("b2b_wcnt", 32'(win_cnt), 32'd6);
      pulses = 0;
      repeat (3) step(1'b1, 32'h4100_0000, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      chk("fl_busy", 32'(busy), 32'd0);
      chk("fl_valid", 32'(out_valid), 32'd0);
      win4(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000);
      chk("fl_data", out_data, 32'h3F00_0000);
      chk("fl_pulses", 32'(pulses), 32'd1);
      chk("fl_wcnt", 32'(win_cnt), 32'd7);
      repeat (3) step(1'b1, 32'h4000_0000, 1'b0);
      step(1'b1, 32'h40A0_0000, 1'b1);
      chk("fl4_valid", 32'(out_valid), 32'd0);
      chk("fl4_busy", 32'(busy), 32'd0);
      chk("fl4_wcnt", 32'(win_cnt), 32'd7);
      chk("fl4_hold", out_data, 32'h3F00_0000);
      step(1'b0, 32'h0, 1'b1);
      chk("fl0_busy", 32'(busy), 32'd0);
      win4(32'h7F7F_FFFF, 32'h7F80_0000, 32'h0000_0001, 32'hFF80_0000);
      chk("inf_data", out_data, 32'h7F80_0000);
      chk("inf_wcnt", 32'(win_cnt), 32'd8);
      step(1'b1, 32'h4000_0000, 1'b0);
      step(1'b1, 32'h4000_0000, 1'b0);
      rst = 1'b1;
      step(1'b1, 32'h4000_0000, 1'b0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_wcnt", 32'(win_cnt), 32'd0);
      chk("mrst_data", out_data, 32'd0);
      rst = 1'b0;
      pulses = 0;
      step(1'b1, 32'h3E80_0000, 1'b0);
      step(1'b1, 32'h3E00_0000, 1'b0);
      step(1'b1, 32'h3E00_0000, 1'b0);
      chk("mrst_nopulse", 32'(pulses), 32'd0);
      step(1'b1, 32'h3E00_0000, 1'b0);
      chk("mrst_data2", out_data, 32'h3E80_0000);
      chk("mrst_wcnt2", 32'(win_cnt), 32'd1);
      for (int i = 0; i < 254; i++) win4(32'h1, 32'h2, 32'h3, 32'h4);
      chk("wrap_pre", 32'(win_cnt), 32'd255);
      win4(32'h1, 32'h2, 32'h3, 32'h4);
      chk("wrap_wcnt", 32'(win_cnt), 32'd0);
      chk("wrap_data", out_data, 32'h4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
